// File: rtl/ysyx_22040175_ifu.sv
// Instruction fetch unit: one outstanding request to instruction memory, selects the
// addressed 32-bit word from a 64-bit response and holds it under a valid/ready handshake.
module ysyx_22040175_ifu #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int MEM_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  fetch_req,
   input  logic                  flush,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic                  misalign,
   output logic [31:0]           fetch_cnt,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [MEM_WIDTH-1:0]  imem_rsp_data,
   output logic                  imem_rsp_ready
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      DRAIN = 3'd3,
      VALID = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic                  misalign_q, misalign_d;
   logic [31:0]           fetch_cnt_q, fetch_cnt_d;
   logic [INST_WIDTH-1:0] rsp_word;

   // addr_q[2] picks which half of the doubleword holds the instruction
   assign rsp_word = addr_q[2] ? imem_rsp_data[2*INST_WIDTH-1:INST_WIDTH]
                               : imem_rsp_data[INST_WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         inst_q      <= '0;
         misalign_q  <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         inst_q      <= inst_d;
         misalign_q  <= misalign_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      inst_d      = inst_q;
      misalign_d  = misalign_q;
      fetch_cnt_d = fetch_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (fetch_req && !flush) begin
               if (pc[1:0] != 2'b00) begin
                  inst_d     = '0;
                  misalign_d = 1'b1;
                  state_d    = VALID;
               end else begin
                  addr_d  = pc;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            // An accepted request must still be answered, so a flush here drains it
            if (imem_req_ready) begin
               state_d = flush ? DRAIN : WAIT;
            end else if (flush) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (flush) begin
                  state_d = IDLE;
               end else begin
                  inst_d     = rsp_word;
                  misalign_d = 1'b0;
                  state_d    = VALID;
               end
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (imem_rsp_valid) begin
               state_d = IDLE;
            end
         end
         VALID: begin
            if (flush) begin
               state_d = IDLE;
            end else if (inst_ready) begin
               fetch_cnt_d = fetch_cnt_q + 32'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign inst           = inst_q;
   assign misalign       = misalign_q;
   assign fetch_cnt      = fetch_cnt_q;
   assign inst_valid     = (state_q == VALID);
   assign imem_req_valid = (state_q == REQ);
   assign imem_rsp_ready = (state_q == WAIT) || (state_q == DRAIN);
   assign imem_req_addr  = {addr_q[ADDR_WIDTH-1:3], 3'b000};

endmodule

// File: doc/ysyx_22040175_ifu.md
# ysyx_22040175_ifu

Instruction fetch unit between the PC register and instruction memory. It takes the current fetch address from the PC stage and issues one request at a time over a valid/ready memory interface. It selects the addressed 32-bit word from the 64-bit memory response and holds it for the decode/execute datapath under a valid/ready handshake. Redirects (branch/jump) flush any in-flight fetch; a late response is drained and discarded.

## Interface
Parameters:
- ADDR_WIDTH, 32, fetch address width (matches `CPU_WIDTH`)
- INST_WIDTH, 32, instruction width
- MEM_WIDTH, 64, memory response data width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc  in  ADDR_WIDTH  fetch address from PC stage
- fetch_req  in  1  level; core wants the instruction at pc
- flush  in  1  redirect; abandon current fetch
- inst  out  INST_WIDTH  fetched instruction
- inst_valid  out  1  inst (or misalign) is valid
- inst_ready  in  1  core consumes inst this cycle
- misalign  out  1  qualifies inst_valid; pc[1:0] != 0
- fetch_cnt  out  32  count of delivered instructions
- imem_req_valid  out  1  memory request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_WIDTH  request address, aligned to 8 bytes
- imem_rsp_valid  in  1  memory response valid
- imem_rsp_data  in  MEM_WIDTH  response doubleword
- imem_rsp_ready  out  1  unit accepts response

## Operation
- States: IDLE, REQ, WAIT, DRAIN, VALID. All outputs registered or decoded from state only.
- IDLE: if fetch_req && !flush:
  - pc[1:0] != 0: load inst=0, misalign=1, go to VALID. No memory request.
  - Otherwise: latch addr_q=pc, go to REQ.
- REQ: imem_req_valid=1, imem_req_addr={addr_q[ADDR_WIDTH-1:3],3'b0}, held stable until handshake.
  - req_valid&&req_ready: go to WAIT.
  - flush without handshake: go to IDLE; the request is withdrawn.
  - flush with handshake in the same cycle: go to DRAIN.
- WAIT: imem_rsp_ready=1.
  - rsp_valid: inst = addr_q[2] ? rsp_data[63:32] : rsp_data[31:0]; misalign=0; go to VALID.
  - flush with rsp_valid in the same cycle: data discarded, go to IDLE.
  - flush without rsp_valid: go to DRAIN.
- DRAIN: imem_rsp_ready=1. On rsp_valid, discard the data and go to IDLE. flush is ignored here.
- VALID: inst_valid=1; inst and misalign are held stable.
  - inst_ready: fetch_cnt += 1 (wraps at 2^32, including misalign deliveries), go to IDLE.
  - flush: go to IDLE without counting. flush has priority over inst_ready.
- Only one outstanding memory request at any time. imem_rsp_ready=0 in IDLE, REQ and VALID.
- pc changes are ignored outside IDLE; addr_q is the only address used.

## Timing
- Reset values: state=IDLE, inst=0, inst_valid=0, misalign=0, fetch_cnt=0, imem_req_valid=0, imem_req_addr=0, imem_rsp_ready=0.
- Reset is asynchronous. Asserting it mid-transaction returns the unit to IDLE immediately. The memory side must tolerate an abandoned request or response.
- Zero-wait memory (req_ready=1, rsp one cycle after accept): fetch_req sampled at edge 0, req_valid in cycle 1, rsp in cycle 2, inst_valid in cycle 3. Latency is 3 cycles.
- Throughput is one instruction per 4 cycles at best, because VALID always returns to IDLE.
- Misaligned pc: inst_valid with misalign=1 in the cycle after fetch_req is sampled.
- inst_valid stays high until inst_ready or flush. It is never dropped otherwise.

## Test plan
- Aligned fetch, zero-wait: pc=0x80000004, rsp_data=0x00100093_00000013 -> inst=0x00100093 in cycle 3, req_addr=0x80000000, fetch_cnt=1 after inst_ready.
- Backpressure: req_ready low 5 cycles, then inst_ready low 4 cycles -> req_valid and addr held stable the whole time; inst held stable; exactly one request issued; fetch_cnt increments once.
- Flush in WAIT: flush asserted 1 cycle after the request is accepted, response arrives 3 cycles later -> response absorbed in DRAIN, no inst_valid, fetch_cnt unchanged, next fetch (pc=0x80000010) returns the low word correctly.
- Flush coincident with req handshake -> DRAIN entered; the stale response is never delivered.
- Misaligned pc=0x80000002 -> no imem_req_valid, inst_valid=1, misalign=1, inst=0 next cycle.
- Async reset asserted in VALID with fetch_cnt=7 -> all outputs go to reset values without waiting for a clock edge; fetch_cnt=0.
